dbus_responder: RTL and testbench

Data-bus responder: the memory-side end of the core's `dbus_req_t`/`dbus_resp_t` interface. It accepts one request at a time, models a byte-strobed 64-bit-wide SRAM with a configurable fixed latency, and returns a single-cycle acknowledge. It is used in simulation and FPGA bring-up in place of the cache/AXI path. It can also be instantiated twice, with `ibus` adapted to `dbus` format, to serve instruction fetch.

---
 rtl/common_pkg.sv | 43 ++++
 rtl/dbus_ram.sv | 40 ++++
 rtl/dbus_responder.sv | 157 +++++++++++++++
 tb/tb_dbus_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the core's data-bus interface and the bus responder.
//
// Contents:
//   dbus_req_t         request  : valid, addr, size, strobe[7:0], data[63:0]
//   dbus_resp_t        response : addr_ok, data_ok, data[63:0]
//   dbus_resp_state_t  responder FSM states (IDLE, WAIT, ACK)
//   DBUS_WORD_BYTES    bytes per bus word
package common;

  localparam int DBUS_WORD_BYTES = 8;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [DBUS_WORD_BYTES-1:0] strobe_t;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } dbus_resp_state_t;

endpackage

// File: rtl/dbus_ram.sv
// Synchronous-read, byte-strobed-write word array behind dbus_responder.
//
// Ports:
//   clk    in   clock
//   en     in   access enable; a read of word idx is registered into rdata,
//                and strobed bytes of wdata are written to word idx
//   idx    in   word index
//   strobe in   byte write enables (all zero = pure read)
//   wdata  in   write data
//   rdata  out  word read on the previous enabled cycle (pre-write contents)
module dbus_ram
  import common::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [AW-1:0]              idx,
  input  logic [DBUS_WORD_BYTES-1:0] strobe,
  input  logic [63:0]                wdata,
  output logic [63:0]                rdata
);

  logic [63:0] mem_q [DEPTH];

  // NOTE: the array has no reset on purpose; it maps onto block RAM and its
  // contents must survive a responder reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_q[idx];
      for (int b = 0; b < DBUS_WORD_BYTES; b++) begin
        if (strobe[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Memory-side end of the core's data bus: accepts one request at a time,
// answers after a fixed LATENCY with a one-cycle addr_ok/data_ok pulse, and
// backs it with a DEPTH x 64-bit byte-strobed array mapped at BASE.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset
//   dreq   in   request (valid, addr, size, strobe, data)
//   dresp  out  response (addr_ok, data_ok, data); driven from registers only
//   busy   out  a transaction is latched and not yet acknowledged
//   err    out  sticky out-of-range flag, cleared only by reset
module dbus_responder
  import common::*;
#(
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy,
  output logic       err
);

  localparam int          AW   = $clog2(DEPTH);
  // Wide enough to hold LATENCY-2, the initial WAIT count.
  localparam int          CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'(DBUS_WORD_BYTES);

  dbus_resp_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             inrange_q, inrange_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  // Decode of the incoming address; only used on the acceptance cycle.
  logic [63:0]   req_off;
  logic [AW-1:0] req_idx;
  logic          req_inrange;

  assign req_off     = dreq.addr - BASE;
  assign req_idx     = req_off[AW+2:3];
  assign req_inrange = (dreq.addr >= BASE) && (dreq.addr < BASE + SPAN);

  // Size and sub-word address bits play no part: data/strobe arrive pre-aligned.
  logic unused_req;
  assign unused_req = ^{dreq.size, req_off[63:AW+3], req_off[2:0]};

  // RAM control: read on the cycle that enters ACK so rdata is ready in ACK;
  // write in ACK itself, after the pre-write word has been captured.
  logic          ram_rd, ram_wr, ram_en;
  logic [AW-1:0] ram_idx;
  logic [7:0]    ram_strobe;
  logic [63:0]   ram_rdata;

  assign ram_rd     = ((state_q == IDLE) && dreq.valid && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q == '0));
  assign ram_wr     = (state_q == ACK) && inrange_q && (strobe_q != 8'h00);
  assign ram_en     = ram_rd || ram_wr;
  assign ram_idx    = (state_q == IDLE) ? req_idx : idx_q;
  assign ram_strobe = ram_wr ? strobe_q : 8'h00;

  dbus_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .en     (ram_en),
    .idx    (ram_idx),
    .strobe (ram_strobe),
    .wdata  (wdata_q),
    .rdata  (ram_rdata)
  );

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    inrange_d = inrange_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          idx_d     = req_idx;
          inrange_d = req_inrange;
          strobe_d  = dreq.strobe;
          wdata_d   = dreq.data;
          if (LATENCY == 1) begin
            state_d = ACK;
          end else begin
            cnt_d   = CW'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        if (!inrange_q) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values of the others regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      inrange_q <= 1'b0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      inrange_q <= inrange_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  // Response decodes registered state only, so it cannot follow dreq.
  always_comb begin
    dresp = '0;
    if (state_q == ACK) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = inrange_q ? ram_rdata : 64'h0;
    end
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: four instances (LATENCY 2, 1, 5, 4), each with a
// transaction-level model (acceptance cycle + LATENCY, word-addressed memory)
// checked every cycle, plus directed literal expectations.
module tb_dbus_responder;
  import common::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 5;
      default: return 4;
    endcase
  endfunction

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic longint word_of(input logic [63:0] a);
    return longint'((a - BASE) >> 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst   [4];
  dbus_req_t  req   [4];
  dbus_resp_t resp  [4];
  logic       busy  [4];
  logic       err   [4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int L = lat_of(g);

    dbus_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (L),
      .BASE    (BASE)
    ) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .dreq  (req[g]),
      .dresp (resp[g]),
      .busy  (busy[g]),
      .err   (err[g])
    );

    // Model: a transaction is due exactly L cycles after its acceptance.
    logic [63:0] mem_m [longint];
    bit          pending = 1'b0;
    bit          err_m   = 1'b0;
    int          ack_cyc = 0;
    int          ncyc    = 0;
    dbus_req_t   lat_req;

    always @(negedge clk) begin
      bit          ack_e;
      bit          inr;
      longint      w;
      logic [63:0] nw;
      ncyc++;
      if (rst[g]) begin
        check($sformatf("L%0d_rst_ok", L), 64'({resp[g].addr_ok, resp[g].data_ok}), 64'd0);
        check($sformatf("L%0d_rst_data", L), resp[g].data, 64'd0);
        check($sformatf("L%0d_rst_busy", L), 64'(busy[g]), 64'd0);
        check($sformatf("L%0d_rst_err", L), 64'(err[g]), 64'd0);
        pending = 1'b0;
        err_m   = 1'b0;
      end else begin
        ack_e = pending && (ncyc == ack_cyc);
        check($sformatf("L%0d_data_ok", L), 64'(resp[g].data_ok), 64'(ack_e));
        check($sformatf("L%0d_addr_ok", L), 64'(resp[g].addr_ok), 64'(ack_e));
        check($sformatf("L%0d_busy", L), 64'(busy[g]), 64'(pending));
        check($sformatf("L%0d_err", L), 64'(err[g]), 64'(err_m));
        if (ack_e) begin
          inr = in_range(lat_req.addr);
          w   = word_of(lat_req.addr);
          if (!inr) begin
            check($sformatf("L%0d_oor_data", L), resp[g].data, 64'd0);
          end else if (mem_m.exists(w)) begin
            check($sformatf("L%0d_rdata", L), resp[g].data, mem_m[w]);
          end
          if (inr && (lat_req.strobe != 8'h00) &&
              (mem_m.exists(w) || lat_req.strobe == 8'hFF)) begin
            nw = mem_m.exists(w) ? mem_m[w] : 64'h0;
            for (int b = 0; b < 8; b++) begin
              if (lat_req.strobe[b]) nw[8*b +: 8] = lat_req.data[8*b +: 8];
            end
            mem_m[w] = nw;
          end
          if (!inr) err_m = 1'b1;
          pending = 1'b0;
        end else if (!pending && req[g].valid) begin
          pending = 1'b1;
          ack_cyc = ncyc + L;
          lat_req = req[g];
        end
      end
    end
  end

  // Present a request in the cycle after the previous ack and hold it until
  // data_ok. Optionally scramble addr/data while the transaction waits.
  task automatic txn(input int i, input logic [63:0] addr, input logic [7:0] strobe,
                     input logic [63:0] data, input bit churn,
                     output logic [63:0] rd, output int lat, output int at);
    int start;
    @(posedge clk); #1;
    req[i].valid  = 1'b1;
    req[i].addr   = addr;
    req[i].size   = MSIZE8;
    req[i].strobe = strobe;
    req[i].data   = data;
    start = cyc;
    lat = -1;
    at  = -1;
    rd  = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (resp[i].data_ok) begin
        rd  = resp[i].data;
        lat = cyc - start;
        at  = cyc;
        break;
      end
      if (churn && n == 1) begin
        @(posedge clk); #1;
        req[i].addr = 64'h8000_0108;
        req[i].data = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    req[i].valid = 1'b0;
  endtask

  // Four back-to-back transactions with valid held high throughout.
  task automatic burst(input int i, input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] rd;
    int lat, at, prev;
    int l;
    l = lat_of(i);
    txn(i, 64'h8000_0040, 8'hFF, d0, 1'b0, rd, lat, at);
    check($sformatf("L%0d_burst_lat0", l), 64'(lat), 64'(l));
    prev = at;
    txn(i, 64'h8000_0048, 8'hFF, d1, 1'b0, rd, lat, at);
    check($sformatf("L%0d_burst_lat1", l), 64'(lat), 64'(l));
    check($sformatf("L%0d_burst_gap1", l), 64'(at - prev), 64'(l + 1));
    prev = at;
    txn(i, 64'h8000_0040, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check($sformatf("L%0d_burst_lat2", l), 64'(lat), 64'(l));
    check($sformatf("L%0d_burst_gap2", l), 64'(at - prev), 64'(l + 1));
    check($sformatf("L%0d_burst_rd0", l), rd, d0);
    prev = at;
    txn(i, 64'h8000_0048, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check($sformatf("L%0d_burst_lat3", l), 64'(lat), 64'(l));
    check($sformatf("L%0d_burst_gap3", l), 64'(at - prev), 64'(l + 1));
    check($sformatf("L%0d_burst_rd1", l), rd, d1);
    idle(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    int lat, at;

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      req[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_ok", 64'(resp[0].data_ok), 64'd0);
    check("reset_busy", 64'(busy[0]), 64'd0);
    check("reset_err", 64'(err[0]), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // LATENCY=2: full write, read back, byte-strobed merge.
    txn(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, rd, lat, at);
    check("l2_wr_lat", 64'(lat), 64'd2);
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("l2_rd_lat", 64'(lat), 64'd2);
    check("l2_rd_data", rd, 64'h1122_3344_5566_7788);
    txn(0, 64'h8000_0010, 8'h0C, 64'h0000_0000_AABB_0000, 1'b0, rd, lat, at);
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("l2_strobe_merge", rd, 64'h1122_3344_AABB_7788);

    // Out-of-range read and write.
    txn(0, 64'h8000_0000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, rd, lat, at);
    txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("oor_rd_data", rd, 64'h0);
    idle(0);
    check("oor_err_set", 64'(err[0]), 64'd1);
    txn(0, 64'h8000_8000, 8'hFF, 64'h5555_5555_5555_5555, 1'b0, rd, lat, at);
    check("oor_wr_lat", 64'(lat), 64'd2);
    idle(0);
    check("oor_err_sticky", 64'(err[0]), 64'd1);
    txn(0, 64'h8000_0000, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("oor_word0_intact", rd, 64'hDEAD_BEEF_CAFE_F00D);
    idle(0);

    // Latency sweep with valid held continuously.
    burst(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    burst(2, 64'hA5A5_0000_5A5A_FFFF, 64'h0F0F_F0F0_3C3C_C3C3);

    // Request churn during WAIT (LATENCY=5).
    txn(2, 64'h8000_0108, 8'hFF, 64'h9999_8888_7777_6666, 1'b0, rd, lat, at);
    txn(2, 64'h8000_0100, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b1, rd, lat, at);
    check("churn_lat", 64'(lat), 64'd5);
    txn(2, 64'h8000_0100, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("churn_latched_wr", rd, 64'h0F0E_0D0C_0B0A_0908);
    txn(2, 64'h8000_0108, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("churn_other_intact", rd, 64'h9999_8888_7777_6666);
    idle(2);

    // Reset while a write waits (LATENCY=4).
    txn(3, 64'h8000_0020, 8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b0, rd, lat, at);
    check("l4_wr_lat", 64'(lat), 64'd4);
    idle(3);
    @(posedge clk); #1;
    req[3].valid  = 1'b1;
    req[3].addr   = 64'h8000_0020;
    req[3].strobe = 8'hFF;
    req[3].data   = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    check("rst_mid_busy_before", 64'(busy[3]), 64'd1);
    rst[3]       = 1'b1;
    req[3].valid = 1'b0;
    #1;
    check("rst_mid_data_ok", 64'(resp[3].data_ok), 64'd0);
    check("rst_mid_busy", 64'(busy[3]), 64'd0);
    check("rst_mid_data", resp[3].data, 64'd0);
    @(posedge clk); #1;
    rst[3] = 1'b0;
    repeat (6) @(posedge clk);
    txn(3, 64'h8000_0020, 8'h00, 64'h0, 1'b0, rd, lat, at);
    check("rst_mid_old_value", rd, 64'h1234_5678_9ABC_DEF0);
    check("rst_mid_rd_lat", 64'(lat), 64'd4);
    idle(3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
